// File: rtl/sobel_edge_stage_pkg.sv
// Shared definitions for the Sobel edge stage.
//   LATENCY        : fixed clock depth of the pixel pipeline (post_* vs per_*)
//   COEF_R/G/B     : RGB888 -> 8-bit luma weights, sum of weights is 256
//   EDGE/BG colour : RGB565 words emitted for edge / background pixels
//   expand5/6      : RGB565 channel widening by replicating the top bits
package sobel_edge_stage_pkg;

  localparam int          LATENCY    = 6;
  localparam int          PIX_W      = 16;
  localparam int          ROW_W      = 10;
  localparam logic [9:0]  ROW_MAX    = 10'd1023;

  localparam logic [7:0]  COEF_R     = 8'd77;
  localparam logic [7:0]  COEF_G     = 8'd150;
  localparam logic [7:0]  COEF_B     = 8'd29;

  localparam logic [15:0] EDGE_COLOR = 16'hFFFF;
  localparam logic [15:0] BG_COLOR   = 16'h0000;

  function automatic logic [7:0] expand5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

endpackage

// File: rtl/sobel_edge_stage_if.sv
// Camera-style pixel stream bundle.
//   frame_vsync : frame sync level
//   frame_href  : line-active level
//   frame_clken : pixel strobe
//   img_data    : RGB565 pixel
// Handshake: img_data is a pixel on every rising clk where frame_clken is 1.
// There is no ready; the receiver must accept every strobed pixel, and
// vsync/href are plain timing levels carried alongside the stream.
// master drives the stream, slave receives it.
interface sobel_edge_stage_if;
  import sobel_edge_stage_pkg::*;

  logic             frame_vsync;
  logic             frame_href;
  logic             frame_clken;
  logic [PIX_W-1:0] img_data;

  modport master (output frame_vsync, frame_href, frame_clken, img_data);
  modport slave  (input  frame_vsync, frame_href, frame_clken, img_data);

endinterface

// File: rtl/sobel_line_buffer.sv
// Single-port line RAM with read-before-write behaviour.
//   clk, rst_n : clock, async active-low reset (read register only)
//   en         : access strobe; read and write happen together
//   addr       : word address
//   wdata      : data written at addr when en
//   rdata      : previous contents of addr, one clock after en; holds
//                its value while en is low
// The memory array itself is not reset.
module sobel_line_buffer #(
  parameter  int DEPTH = 640,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wdata;
  end

  // Nonblocking read of the same word returns the value before this write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/sobel_edge_stage.sv
// Streaming 3x3 Sobel edge detector on an RGB565 camera stream.
//   clk, rst_n : pixel clock, async active-low reset
//   per        : input stream (slave)  - capture output
//   post       : output stream (master) - white/black edge map, all
//                strobes delayed by exactly LATENCY clocks
//   IMG_HDISP  : active pixels per line (line-buffer depth)
//   THRESH     : edge when |Gx|+|Gy| >= THRESH
// Pipeline (stage registers, clock after the input sample):
//   s1 luma products | s2 luma sum, line A access | s3 window, line B access
//   s4 Gx/Gy | s5 magnitude | s6 threshold/border -> post_img_data
module sobel_edge_stage
  import sobel_edge_stage_pkg::*;
#(
  parameter int          IMG_HDISP = 640,
  parameter logic [10:0] THRESH    = 11'd160
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_edge_stage_if.slave  per,
  sobel_edge_stage_if.master post
);

  localparam int            CW      = $clog2(IMG_HDISP);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP - 1);

  // ---------------- line/frame position ----------------
  logic             href_d, vsync_d;
  logic             href_fall, vsync_rise;
  logic [CW-1:0]    col;
  logic [ROW_W-1:0] row;
  logic             border_now;

  assign href_fall  = href_d & ~per.frame_href;
  assign vsync_rise = ~vsync_d & per.frame_vsync;
  // Position of the pixel being sampled now (the newest window column).
  assign border_now = (row < 10'd2) || (col < CW'(2));

  // A pixel arriving with the href falling edge uses the old col; the
  // clear takes priority over its increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_d  <= 1'b0;
      vsync_d <= 1'b0;
      col     <= '0;
      row     <= '0;
    end else begin
      href_d  <= per.frame_href;
      vsync_d <= per.frame_vsync;
      if (href_fall)
        col <= '0;
      else if (per.frame_clken && col != COL_MAX)
        col <= col + CW'(1);
      if (vsync_rise)
        row <= '0;
      else if (href_fall && row != ROW_MAX)
        row <= row + 10'd1;
    end
  end

  // ---------------- timing delay lines ----------------
  // ce_d[k] is the pixel-valid flag belonging to pipeline stage k+1.
  logic [LATENCY-1:0] vs_d, hs_d, ce_d;
  logic [LATENCY-2:0] bd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= '0;
      hs_d <= '0;
      ce_d <= '0;
      bd_d <= '0;
    end else begin
      vs_d <= {vs_d[LATENCY-2:0], per.frame_vsync};
      hs_d <= {hs_d[LATENCY-2:0], per.frame_href};
      ce_d <= {ce_d[LATENCY-2:0], per.frame_clken};
      bd_d <= {bd_d[LATENCY-3:0], border_now};
    end
  end

  // ---------------- luma ----------------
  logic [7:0]    r8, g8, b8;
  logic [15:0]   prod_r, prod_g, prod_b, luma_sum;
  logic [7:0]    y_next, y_q;
  logic [CW-1:0] col_s1, col_s2;

  assign r8 = expand5(per.img_data[15:11]);
  assign g8 = expand6(per.img_data[10:5]);
  assign b8 = expand5(per.img_data[4:0]);

  assign luma_sum = prod_r + prod_g + prod_b;
  assign y_next   = 8'(luma_sum >> 8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r <= '0;
      prod_g <= '0;
      prod_b <= '0;
      y_q    <= '0;
      col_s1 <= '0;
      col_s2 <= '0;
    end else begin
      prod_r <= {8'd0, r8} * {8'd0, COEF_R};
      prod_g <= {8'd0, g8} * {8'd0, COEF_G};
      prod_b <= {8'd0, b8} * {8'd0, COEF_B};
      y_q    <= y_next;
      col_s1 <= col;
      col_s2 <= col_s1;
    end
  end

  // ---------------- line buffers ----------------
  // Buffer A is accessed with the luma sum as it is registered, so its
  // old word (row-1) is ready one clock later; that word is then written
  // into buffer B while B's old word (row-2) is read out.
  logic [7:0] a_rdata, b_rdata;

  sobel_line_buffer #(.DEPTH(IMG_HDISP), .WIDTH(8)) u_buf_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ce_d[0]),
    .addr  (col_s1),
    .wdata (y_next),
    .rdata (a_rdata)
  );

  sobel_line_buffer #(.DEPTH(IMG_HDISP), .WIDTH(8)) u_buf_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ce_d[1]),
    .addr  (col_s2),
    .wdata (a_rdata),
    .rdata (b_rdata)
  );

  // ---------------- 3x3 window ----------------
  // The newest top-row tap p13 is buffer B's read register itself; it
  // updates on the same valid clock as the other taps.
  logic [7:0] p11, p12, p21, p22, p23, p31, p32, p33;
  logic [7:0] p13;

  assign p13 = b_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p11 <= '0; p12 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
    end else if (ce_d[1]) begin
      p11 <= p12; p12 <= p13;
      p21 <= p22; p22 <= p23; p23 <= a_rdata;
      p31 <= p32; p32 <= p33; p33 <= y_q;
    end
  end

  // ---------------- Sobel, magnitude, threshold ----------------
  function automatic logic signed [10:0] sx(input logic [7:0] p);
    return $signed({3'b000, p});
  endfunction

  logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
  logic [10:0]        abs_x, abs_y, mag_d, mag_q;
  logic [15:0]        out_q;

  assign gx_d = (sx(p13) + (sx(p23) <<< 1) + sx(p33))
              - (sx(p11) + (sx(p21) <<< 1) + sx(p31));
  assign gy_d = (sx(p31) + (sx(p32) <<< 1) + sx(p33))
              - (sx(p11) + (sx(p12) <<< 1) + sx(p13));

  assign abs_x = gx_q[10] ? $unsigned(-gx_q) : $unsigned(gx_q);
  assign abs_y = gy_q[10] ? $unsigned(-gy_q) : $unsigned(gy_q);
  assign mag_d = abs_x + abs_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q  <= '0;
      gy_q  <= '0;
      mag_q <= '0;
      out_q <= BG_COLOR;
    end else begin
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      mag_q <= mag_d;
      out_q <= (ce_d[LATENCY-2] && !bd_d[LATENCY-2] && mag_q >= THRESH)
               ? EDGE_COLOR : BG_COLOR;
    end
  end

  assign post.frame_vsync = vs_d[LATENCY-1];
  assign post.frame_href  = hs_d[LATENCY-1];
  assign post.frame_clken = ce_d[LATENCY-1];
  assign post.img_data    = out_q;

endmodule

// File: tb/tb_sobel_edge_stage.sv
// Self-checking bench for sobel_edge_stage. Three instances share one input
// stream and differ only in THRESH (160, 1020, 1021). A frame-level image
// model predicts each output pixel when it is issued; a negedge monitor
// pops and compares, and also checks the strobe delay line.
`timescale 1ns/1ps
module tb_sobel_edge_stage;

  localparam int W    = 640;
  localparam int H    = 8;
  localparam int SENT = 32'h3fff_ffff;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_edge_stage_if per_if ();
  sobel_edge_stage_if post_a ();
  sobel_edge_stage_if post_b ();
  sobel_edge_stage_if post_c ();

  sobel_edge_stage #(.IMG_HDISP(W), .THRESH(11'd160)) dut_a (
    .clk(clk), .rst_n(rst_n), .per(per_if), .post(post_a));
  sobel_edge_stage #(.IMG_HDISP(W), .THRESH(11'd1020)) dut_b (
    .clk(clk), .rst_n(rst_n), .per(per_if), .post(post_b));
  sobel_edge_stage #(.IMG_HDISP(W), .THRESH(11'd1021)) dut_c (
    .clk(clk), .rst_n(rst_n), .per(per_if), .post(post_c));

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  int          mcyc     = 0;
  int          rel_cyc  = SENT;
  int          out_count = 0;
  int          row_base = 0;
  logic [47:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [2:0]  hist [64];
  int          yimg [H][W];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, mcyc);
  endtask

  // ---------------- reference model ----------------
  function automatic int luma(input logic [15:0] px);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(px[15:11]);
    g6 = int'(px[10:5]);
    b5 = int'(px[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  // Edge value for the window whose newest pixel is image (r, c).
  function automatic logic [15:0] model(input int r, input int c, input int thr);
    int gx, gy, rc;
    rc = r - row_base;
    if (rc < 2 || c < 2) return 16'h0000;
    gx = (yimg[r-2][c] + 2 * yimg[r-1][c] + yimg[r][c])
       - (yimg[r-2][c-2] + 2 * yimg[r-1][c-2] + yimg[r][c-2]);
    gy = (yimg[r][c-2] + 2 * yimg[r][c-1] + yimg[r][c])
       - (yimg[r-2][c-2] + 2 * yimg[r-2][c-1] + yimg[r-2][c]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return (gx + gy >= thr) ? 16'hFFFF : 16'h0000;
  endfunction

  function automatic logic [15:0] pick_px(input int pattern, input int c);
    case (pattern)
      0: return 16'h7BEF;
      1: return (c < 8) ? 16'h0000 : 16'hFFFF;
      default: begin
        case ($urandom_range(0, 3))
          0: return 16'h0000;
          1: return 16'hFFFF;
          default: return 16'($urandom_range(0, 65535));
        endcase
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vs, input logic hs, input logic ce, input logic [15:0] d);
    per_if.frame_vsync = vs;
    per_if.frame_href  = hs;
    per_if.frame_clken = ce;
    per_if.img_data    = d;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    check("drain_pending", 48'(exp_q.size()), 48'd0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic do_reset(input int clocks);
    drive(0, 0, 0, 16'h0000);
    rst_n   = 1'b0;
    rel_cyc = SENT;
    repeat (clocks) step();
    rst_n   = 1'b1;
    rel_cyc = mcyc;
  endtask

  // pattern: 0 uniform, 1 vertical edge, 2 random; duty in percent.
  task automatic drive_frame(input int pattern, input int duty, input bit mid_reset);
    logic [15:0] px;
    row_base = 0;
    drive(1, 0, 0, 16'h0000);
    repeat (4) step();
    drive(0, 0, 0, 16'h0000);
    repeat (6) step();
    for (int r = 0; r < H; r++) begin
      if (mid_reset && r == 4) begin
        drain();
        do_reset(3);
        row_base = 4;
      end
      for (int c = 0; c < W; c++) begin
        while (duty < 100 && $urandom_range(0, 99) >= duty) begin
          drive(0, 1, 0, 16'($urandom_range(0, 65535)));
          step();
        end
        px = pick_px(pattern, c);
        yimg[r][c] = luma(px);
        exp_q.push_back({model(r, c, 160), model(r, c, 1020), model(r, c, 1021)});
        exp_cyc_q.push_back(mcyc + 6);
        drive(0, 1, 1, px);
        step();
      end
      drive(0, 0, 0, 16'h0000);
      repeat (8) step();
    end
    drain();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [2:0]  exp_s;
    logic [47:0] e;
    int          ec;
    bit          live;
    hist[mcyc % 64] = {per_if.frame_vsync, per_if.frame_href, per_if.frame_clken};
    live  = (mcyc >= 6) && (mcyc - 6 >= rel_cyc);
    exp_s = live ? hist[(mcyc - 6) % 64] : 3'b000;
    check("strobes_a", {post_a.frame_vsync, post_a.frame_href, post_a.frame_clken}, exp_s);
    check("strobes_b", {post_b.frame_vsync, post_b.frame_href, post_b.frame_clken}, exp_s);
    check("strobes_c", {post_c.frame_vsync, post_c.frame_href, post_c.frame_clken}, exp_s);
    if (!live)
      check("reset_data", {post_a.img_data, post_b.img_data, post_c.img_data}, 48'd0);
    if (post_a.frame_clken) begin
      out_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 48'd1, 48'd0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("pixel_data", {post_a.img_data, post_b.img_data, post_c.img_data}, e);
        check("latency", 48'(mcyc), 48'(ec));
      end
    end
    mcyc++;
  end

  // ---------------- watchdog ----------------
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cnt0;
    drive(0, 0, 0, 16'h0000);
    rst_n   = 1'b0;
    rel_cyc = SENT;
    // Inputs toggle while reset is held; outputs must stay 0.
    repeat (10) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)));
      step();
    end
    drive(0, 0, 0, 16'h0000);
    rst_n   = 1'b1;
    rel_cyc = mcyc;
    repeat (4) step();

    cnt0 = out_count;
    drive_frame(0, 100, 1'b0);
    check("uniform_clken_count", 48'(out_count - cnt0), 48'd5120);

    drive_frame(1, 100, 1'b0);
    drive_frame(1, 50, 1'b0);
    drive_frame(2, 70, 1'b0);
    drive_frame(2, 100, 1'b1);
    drive_frame(2, 90, 1'b0);

    repeat (10) step();
    check("final_queue_empty", 48'(exp_q.size()), 48'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
